// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the three producers and the register file write port.
// The slave side is the arbiter; the master side is the producers and register file.
interface regfile_wb_arbiter_if #(
    parameter int NREQ  = 3,
    parameter int CNT_W = 16
);
    logic [NREQ-1:0]      req_valid;
    logic [5*NREQ-1:0]    req_dest;
    logic [32*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 wb_stall;
    logic                 regWrite;
    logic [4:0]           regMemWrite;
    logic [31:0]          writeBack;
    logic [CNT_W-1:0]     wb_count;

    modport slave (
        input  req_valid,
        input  req_dest,
        input  req_data,
        input  wb_stall,
        output req_ready,
        output regWrite,
        output regMemWrite,
        output writeBack,
        output wb_count
    );

    modport master (
        output req_valid,
        output req_dest,
        output req_data,
        output wb_stall,
        input  req_ready,
        input  regWrite,
        input  regMemWrite,
        input  writeBack,
        input  wb_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among ALU/load/muldiv; round-robin when WB_RR_ARB_EN, else fixed 0>1>2.
// Latency: handshake edge to regWrite is 1 cycle; 1 write/cycle sustained.
// Backpressure: req_ready is combinational and drops to zero with wb_stall or while rst is low.
module regfile_wb_arbiter #(
    parameter int NREQ  = 3,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   wb
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic             gnt_any;
    logic [IDX_W-1:0] gnt_idx;
    logic             arb_ok;
    logic             xfer;
    logic [4:0]       sel_dest;
    logic [31:0]      sel_data;

`ifdef WB_RR_ARB_EN
    logic [IDX_W-1:0] ptr;

    // (base + off) mod NREQ without a divider; off never exceeds NREQ.
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IDX_W'(s);
    endfunction

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && wb.req_valid[rr_idx(ptr, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx(ptr, k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= rr_idx(gnt_idx, 1);
        end
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && wb.req_valid[k]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(k);
            end
        end
    end
`endif

    // Reset gates the grant so nothing handshakes while the outputs are held cleared.
    assign arb_ok = rst && !wb.wb_stall;
    assign xfer   = gnt_any && arb_ok;

    always_comb begin
        wb.req_ready = '0;
        if (xfer) begin
            wb.req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        int b5;
        int b32;
        b5       = int'(gnt_idx) * 5;
        b32      = int'(gnt_idx) * 32;
        sel_dest = wb.req_dest[b5 +: 5];
        sel_data = wb.req_data[b32 +: 32];
    end

    // Dest 0 is consumed and latched but never enables the write or the counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb.regWrite    <= 1'b0;
            wb.regMemWrite <= '0;
            wb.writeBack   <= '0;
            wb.wb_count    <= '0;
        end else begin
            wb.regWrite <= 1'b0;
            if (xfer) begin
                wb.regMemWrite <= sel_dest;
                wb.writeBack   <= sel_data;
                wb.regWrite    <= |sel_dest;
                if (|sel_dest) begin
                    wb.wb_count <= wb.wb_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
